// File: rtl/mul_unit_rr_controller.sv
// Round-robin arbiter and sequencer sharing one registered 8x8 multiply unit
// between two valid/ready requesters, returning the truncated product per channel.
module mul_unit_rr_controller #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    input  logic       rsp0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    input  logic       rsp1_ready,
    output logic [7:0] mul_a,
    output logic [7:0] mul_b,
    output logic       mul_init,
    input  logic [7:0] mul_out,
    output logic       busy,
    output logic       grant_id,
    output logic [7:0] done_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MUL_LATENCY - 1);

    state_t     state_q, state_d;
    logic [7:0] opA_q, opA_d;
    logic [7:0] opB_q, opB_d;
    logic [7:0] result_q, result_d;
    logic       grantId_q, grantId_d;
    logic [7:0] doneCount_q, doneCount_d;
    logic       prefer1_q, prefer1_d;
    logic [3:0] cnt_q, cnt_d;

    logic winner1;
    logic anyValid;
    logic rspHandshake;

    // Channel 1 wins when it is the only requester or when the pointer favours it.
    assign winner1      = req1_valid && (!req0_valid || prefer1_q);
    assign anyValid     = req0_valid || req1_valid;
    assign rspHandshake = grantId_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opA_q       <= 8'd0;
            opB_q       <= 8'd0;
            result_q    <= 8'd0;
            grantId_q   <= 1'b0;
            doneCount_q <= 8'd0;
            prefer1_q   <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            result_q    <= result_d;
            grantId_q   <= grantId_d;
            doneCount_q <= doneCount_d;
            prefer1_q   <= prefer1_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        result_d    = result_q;
        grantId_d   = grantId_q;
        doneCount_d = doneCount_q;
        prefer1_d   = prefer1_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    opA_d     = winner1 ? req1_a : req0_a;
                    opB_d     = winner1 ? req1_b : req0_b;
                    grantId_d = winner1;
                    prefer1_d = !winner1;
                    cnt_d     = 4'd0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                result_d = mul_out;
                state_d  = RESP;
            end
            RESP: begin
                if (rspHandshake) begin
                    doneCount_d = doneCount_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands stay on the unit from ISSUE through RESP; init only clears it in IDLE.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp0_data  = 8'd0;
        rsp1_valid = 1'b0;
        rsp1_data  = 8'd0;
        mul_a      = 8'd0;
        mul_b      = 8'd0;
        mul_init   = 1'b0;
        case (state_q)
            IDLE: begin
                mul_init   = 1'b1;
                req0_ready = !rst && req0_valid && !winner1;
                req1_ready = !rst && winner1;
            end
            ISSUE, CAPTURE: begin
                mul_a = opA_q;
                mul_b = opB_q;
            end
            RESP: begin
                mul_a = opA_q;
                mul_b = opB_q;
                if (grantId_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = result_q;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = result_q;
                end
            end
            default: mul_init = 1'b1;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign grant_id   = grantId_q;
    assign done_count = doneCount_q;

endmodule

// File: tb/tb_mul_unit_rr_controller.sv
// Randomised bench for mul_unit_rr_controller: two instances (latency 1 and 3)
// share one stimulus engine checked against a transaction-level arbiter model.
module tb_mul_unit_rr_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       v0, v1, r0, r1;
    logic [7:0] a0, b0, a1, b1;

    logic       rdy0A, rdy1A, rspv0A, rspv1A, mulInitA, busyA, gidA;
    logic [7:0] rspd0A, rspd1A, mulAA, mulBA, mulOutA, doneA;
    logic       rdy0B, rdy1B, rspv0B, rspv1B, mulInitB, busyB, gidB;
    logic [7:0] rspd0B, rspd1B, mulAB, mulBB, mulOutB, doneB;

    always #5 clk = ~clk;

    mul_unit_rr_controller #(.MUL_LATENCY(1)) dutA (
        .clk(clk), .rst(rst),
        .req0_valid(v0 & ~sel), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0A),
        .rsp0_valid(rspv0A), .rsp0_data(rspd0A), .rsp0_ready(r0),
        .req1_valid(v1 & ~sel), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1A),
        .rsp1_valid(rspv1A), .rsp1_data(rspd1A), .rsp1_ready(r1),
        .mul_a(mulAA), .mul_b(mulBA), .mul_init(mulInitA), .mul_out(mulOutA),
        .busy(busyA), .grant_id(gidA), .done_count(doneA)
    );

    mul_unit_rr_controller #(.MUL_LATENCY(3)) dutB (
        .clk(clk), .rst(rst),
        .req0_valid(v0 & sel), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0B),
        .rsp0_valid(rspv0B), .rsp0_data(rspd0B), .rsp0_ready(r0),
        .req1_valid(v1 & sel), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1B),
        .rsp1_valid(rspv1B), .rsp1_data(rspd1B), .rsp1_ready(r1),
        .mul_a(mulAB), .mul_b(mulBB), .mul_init(mulInitB), .mul_out(mulOutB),
        .busy(busyB), .grant_id(gidB), .done_count(doneB)
    );

    // Shared multiply unit models: registered output, init clears the pipeline.
    logic [15:0] prodA, prodB;
    logic [7:0]  pipeB [3];
    assign prodA = 16'(mulAA) * 16'(mulBA);
    assign prodB = 16'(mulAB) * 16'(mulBB);
    always @(posedge clk) mulOutA <= mulInitA ? 8'd0 : prodA[7:0];
    always @(posedge clk) begin
        if (mulInitB) begin
            for (int i = 0; i < 3; i++) pipeB[i] <= 8'd0;
        end else begin
            pipeB[0] <= prodB[7:0];
            pipeB[1] <= pipeB[0];
            pipeB[2] <= pipeB[1];
        end
    end
    assign mulOutB = pipeB[2];

    logic       oRdy0, oRdy1, oRspv0, oRspv1, oInit, oBusy, oGid;
    logic [7:0] oRspd0, oRspd1, oMulA, oMulB, oDone;
    assign oRdy0  = sel ? rdy0B    : rdy0A;
    assign oRdy1  = sel ? rdy1B    : rdy1A;
    assign oRspv0 = sel ? rspv0B   : rspv0A;
    assign oRspv1 = sel ? rspv1B   : rspv1A;
    assign oRspd0 = sel ? rspd0B   : rspd0A;
    assign oRspd1 = sel ? rspd1B   : rspd1A;
    assign oInit  = sel ? mulInitB : mulInitA;
    assign oBusy  = sel ? busyB    : busyA;
    assign oGid   = sel ? gidB     : gidA;
    assign oMulA  = sel ? mulAB    : mulAA;
    assign oMulB  = sel ? mulBB    : mulBA;
    assign oDone  = sel ? doneB    : doneA;

    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    bit          pend [2];
    logic [7:0]  pa [2];
    logic [7:0]  pb [2];
    bit          inflight, curCh, pref, loadAlways;
    int          age, holdCnt;
    logic [7:0]  curA, curB, expRes, modelDone;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int lat();
        return sel ? 3 : 1;
    endfunction

    // One clock cycle: drive after the edge, check at the falling edge, advance the model.
    task automatic applyStimulus(input bit doRst);
        logic [15:0] e;
        bit          w1;
        if (!doRst && !pend[0] && q0.size() > 0 && (loadAlways || $urandom_range(0, 3) != 0)) begin
            e = q0.pop_front(); pa[0] = e[15:8]; pb[0] = e[7:0]; pend[0] = 1'b1;
        end
        if (!doRst && !pend[1] && q1.size() > 0 && (loadAlways || $urandom_range(0, 3) != 0)) begin
            e = q1.pop_front(); pa[1] = e[15:8]; pb[1] = e[7:0]; pend[1] = 1'b1;
        end
        rst = doRst;
        v0  = doRst ? 1'($urandom_range(0, 1)) : pend[0];
        v1  = doRst ? 1'($urandom_range(0, 1)) : pend[1];
        a0  = pend[0] ? pa[0] : 8'($urandom);
        b0  = pend[0] ? pb[0] : 8'($urandom);
        a1  = pend[1] ? pa[1] : 8'($urandom);
        b1  = pend[1] ? pb[1] : 8'($urandom);
        r0  = ($urandom_range(0, 9) < 7);
        r1  = ($urandom_range(0, 9) < 7);
        if (inflight && age + 1 >= lat() + 2 && holdCnt > 0) begin
            if (curCh) r1 = 1'b0; else r0 = 1'b0;
            holdCnt--;
        end
        @(negedge clk);
        if (doRst) begin
            checkOutput("rstReady0", 16'(oRdy0), 16'(0));
            checkOutput("rstReady1", 16'(oRdy1), 16'(0));
            inflight = 1'b0; pref = 1'b0; modelDone = 8'd0; age = 0;
            pend[0] = 1'b0; pend[1] = 1'b0;
        end else if (!inflight) begin
            w1 = pend[1] && (!pend[0] || pref);
            checkOutput("idleReady0", 16'(oRdy0), 16'(pend[0] && !w1));
            checkOutput("idleReady1", 16'(oRdy1), 16'(w1));
            checkOutput("idleBusy", 16'(oBusy), 16'(0));
            checkOutput("idleInit", 16'(oInit), 16'(1));
            checkOutput("idleRspv0", 16'(oRspv0), 16'(0));
            checkOutput("idleRspv1", 16'(oRspv1), 16'(0));
            checkOutput("doneCount", 16'(oDone), 16'(modelDone));
            if (pend[0] || pend[1]) begin
                curCh = w1; curA = pa[w1]; curB = pb[w1];
                expRes = 8'((int'(curA) * int'(curB)) % 256);
                pref = !w1; pend[w1] = 1'b0; inflight = 1'b1; age = 0;
            end
        end else begin
            age++;
            checkOutput("busy", 16'(oBusy), 16'(1));
            checkOutput("busyReady0", 16'(oRdy0), 16'(0));
            checkOutput("busyReady1", 16'(oRdy1), 16'(0));
            checkOutput("grantId", 16'(oGid), 16'(curCh));
            checkOutput("mulA", 16'(oMulA), 16'(curA));
            checkOutput("mulB", 16'(oMulB), 16'(curB));
            checkOutput("mulInit", 16'(oInit), 16'(0));
            checkOutput("doneCount", 16'(oDone), 16'(modelDone));
            if (age <= lat() + 1) begin
                checkOutput("earlyRspv0", 16'(oRspv0), 16'(0));
                checkOutput("earlyRspv1", 16'(oRspv1), 16'(0));
            end else begin
                checkOutput("rspValid", 16'(curCh ? oRspv1 : oRspv0), 16'(1));
                checkOutput("rspData", 16'(curCh ? oRspd1 : oRspd0), 16'(expRes));
                checkOutput("otherValid", 16'(curCh ? oRspv0 : oRspv1), 16'(0));
                checkOutput("otherData", 16'(curCh ? oRspd0 : oRspd1), 16'(0));
                if (curCh ? r1 : r0) begin
                    modelDone = modelDone + 8'd1;
                    inflight  = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pend[0] || pend[1] || inflight) && n < budget) begin
            applyStimulus(1'b0);
            n++;
        end
        checkOutput("drainTimeout", 16'(n >= budget), 16'(0));
    endtask

    task automatic pushOp(input bit ch, input logic [7:0] a, input logic [7:0] b);
        if (ch) q1.push_back({a, b}); else q0.push_back({a, b});
    endtask

    initial begin
        int n;
        sel = 1'b0; rst = 1'b1; v0 = 1'b0; v1 = 1'b0; r0 = 1'b0; r1 = 1'b0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
        pref = 1'b0; inflight = 1'b0; age = 0; holdCnt = 0; modelDone = 8'd0;
        loadAlways = 1'b1; pend[0] = 1'b0; pend[1] = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1);
        applyStimulus(1'b1);

        pushOp(1'b0, 8'd3, 8'd5);
        drain(50);
        checkOutput("singleDone", 16'(oDone), 16'(1));

        applyStimulus(1'b1);
        pushOp(1'b0, 8'd7, 8'd9);   pushOp(1'b1, 8'd2, 8'd200);
        pushOp(1'b0, 8'd7, 8'd9);   pushOp(1'b1, 8'd2, 8'd200);
        drain(100);

        pushOp(1'b0, 8'd20, 8'd13); pushOp(1'b1, 8'd255, 8'd255);
        pushOp(1'b0, 8'd0, 8'd200); pushOp(1'b1, 8'd16, 8'd16);
        drain(100);

        // Backpressure on channel 1 while channel 0 waits.
        pushOp(1'b1, 8'd11, 8'd13);
        n = 0;
        while (!inflight && n < 50) begin applyStimulus(1'b0); n++; end
        checkOutput("bpGrant", 16'(inflight), 16'(1));
        pushOp(1'b0, 8'd4, 8'd4);
        holdCnt = 5;
        drain(100);

        // Reset while the channel 1 operation sits in ISSUE.
        pushOp(1'b1, 8'd9, 8'd9);
        n = 0;
        while (!(inflight && age == 0) && n < 50) begin applyStimulus(1'b0); n++; end
        checkOutput("midGrant", 16'(inflight), 16'(1));
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        pushOp(1'b1, 8'd9, 8'd9);
        drain(50);

        applyStimulus(1'b1);
        for (int i = 0; i < 128; i++) begin
            pushOp(1'b0, 8'($urandom), 8'($urandom));
            pushOp(1'b1, 8'($urandom), 8'($urandom));
        end
        drain(5000);
        checkOutput("doneWrap", 16'(oDone), 16'(0));

        loadAlways = 1'b0;
        for (int i = 0; i < 60; i++) begin
            pushOp(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            if (i % 15 == 0) holdCnt = $urandom_range(1, 6);
        end
        drain(2000);

        sel = 1'b1;
        loadAlways = 1'b1;
        applyStimulus(1'b1);
        pushOp(1'b0, 8'd3, 8'd5);
        drain(50);
        loadAlways = 1'b0;
        for (int i = 0; i < 20; i++) pushOp(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mul_unit_rr_controller.md
Name: mul_unit_rr_controller

Overview:
- Two-requester round-robin arbiter and sequencer for the shared custom 8x8 multiply unit.
- The shared unit has a registered 8-bit output and an init-clears-output input.
- The block accepts operand pairs over valid/ready, drives the unit's operands and init, waits out the unit latency, captures the truncated product and returns it on the granting channel's response valid/ready port.
- It sits between the two compute clients and the single multiply instance.

Parameters:
MUL_LATENCY, 1, clock edges from stable operands with init=0 until mul_out holds the product; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has operands
req0_a  input  8  requester 0 operand a
req0_b  input  8  requester 0 operand b
req0_ready  output  1  requester 0 accepted this cycle (combinational)
rsp0_valid  output  1  result for requester 0 available
rsp0_data  output  8  result for requester 0
rsp0_ready  input  1  requester 0 takes result
req1_valid, req1_a, req1_b, req1_ready, rsp1_valid, rsp1_data, rsp1_ready  same as channel 0, for requester 1
mul_a  output  8  operand a to shared unit
mul_b  output  8  operand b to shared unit
mul_init  output  1  clear request to shared unit
mul_out  input  8  registered product from shared unit
busy  output  1  high in any state other than IDLE
grant_id  output  1  channel currently owning the unit
done_count  output  8  completed responses, wraps

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - op_a, op_b, result, grant_id, done_count are all 0.
  - Priority pointer prefers channel 0.
  - rsp*_valid=0, rsp*_data=0, mul_a=mul_b=0, mul_init=1, busy=0.
  - req*_ready is forced 0 while rst=1.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - mul_init=1, so the shared unit clears.
  - Winner = the single valid requester. If both are valid, the winner is the one the pointer prefers.
  - reqN_ready=1 for the winner only, combinationally.
  - On the edge where valid&ready: latch op_a/op_b, set grant_id=N, set the pointer to prefer the other channel, load cnt=0, go to ISSUE.
- ISSUE:
  - mul_a/mul_b = op_a/op_b (held from ISSUE through RESP); mul_init=0.
  - cnt increments each cycle.
  - After MUL_LATENCY cycles in ISSUE, go to CAPTURE.
- CAPTURE: result <= mul_out (mul_init=0, operands held), then go to RESP.
- RESP:
  - rsp{grant_id}_valid=1 and rsp{grant_id}_data=result.
  - The other channel's rsp_valid=0 and rsp_data=0.
  - Valid and data stay stable until the rsp_ready handshake.
  - On handshake: done_count++ (255 -> 0), go to IDLE.
- Latency: accept edge -> rsp_valid asserted MUL_LATENCY+2 cycles later (3 with default).
- Throughput: one operation per MUL_LATENCY+3 cycles minimum. IDLE is mandatory between operations; no back-to-back accept from RESP.
- Arithmetic: result = (a*b) mod 256, taken unchanged from the unit's low 8 bits; no saturation, no overflow flag.
- req*_ready is 0 in every non-IDLE state. Requests arriving while busy wait; operands are not sampled.
- A losing requester keeps its valid asserted and is guaranteed the next grant (no starvation).
- Reset mid-operation (any state): in-flight operation is discarded, no response is produced, the pointer returns to prefer channel 0, and the next cycle is IDLE with mul_init=1.
- rsp_ready asserted outside RESP is ignored. req_valid deasserted before acceptance is legal; nothing is latched.

Test Plan:
- Reset, then req0 (a=3, b=5) alone.
  - req0_ready=1 in the same cycle.
  - mul_init=0 during ISSUE/CAPTURE.
  - rsp0_valid=1, rsp0_data=15 exactly 3 cycles after accept; rsp1_valid stays 0.
  - done_count=1 after rsp0_ready.
- Both valid right after reset: req0 (7,9), req1 (2,200).
  - req0 granted first -> 63.
  - req1 granted next -> 144.
  - Both re-issued again -> channel 0 is served before channel 1.
- Truncation:
  - 20*13 -> 4.
  - 255*255 -> 1.
  - 0*200 -> 0.
  - 16*16 -> 0.
- Backpressure: hold rsp1_ready=0 for 5 cycles with req0_valid=1.
  - rsp1_valid and rsp1_data stay stable.
  - req0_ready=0 and busy=1 throughout.
  - req0 is granted on the cycle after the rsp1 handshake.
- Reset mid-operation: assert rst for 1 cycle while in ISSUE with req1 (9,9).
  - No rsp1_valid, busy=0, done_count=0.
  - A subsequent req1 (9,9) returns 81.
- Counter wrap and parameter: 256 sequential operations on alternating channels.
  - done_count returns to 0.
  - Repeat the single-request case with MUL_LATENCY=3: rsp_valid 5 cycles after accept, with correct product.
